// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 scan driver: active-high hex glyph table
// (bit 0 = segment a .. bit 6 = segment g) and the supported digit count limit.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  // Entry n is the glyph for nibble n: 0-9, A b C d E F
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment glyph; display polarity is
// applied by the caller.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = glyph_of(i_nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with guard blanking, blank mask and
// leading-zero suppression. Optional decimal point support: SEG7_SCAN_DP_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SLOT_CYCLES    = 50000,
  parameter int GUARD_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
`ifdef SEG7_SCAN_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp_out
`endif
);

  localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_display;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame_tick;

  logic                    w_slot_end;
  logic                    w_idx_last;
  logic                    w_wrap;
  logic                    w_guard;
  logic                    w_lit;
  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [6:0]              w_seg_on;
  logic [NUM_DIGITS-1:0]   w_dig_on;
  logic [NUM_DIGITS-1:0]   w_lz_sup;

  assign w_slot_end = (r_presc == PW'(SLOT_CYCLES - 1));
  assign w_idx_last = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_wrap     = w_slot_end & w_idx_last;
  assign w_guard    = (32'(r_presc) < GUARD_CYCLES);
  assign w_nibble   = r_display[4*int'(r_idx) +: 4];

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  // Prescaler, digit index and the shadow/display double buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_presc <= '0;
        r_idx   <= w_idx_last ? IW'(0) : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (load) begin
        r_shadow <= load_value;
      end
      // Display only changes on the wrap edge so a frame is never torn
      if (w_wrap) begin
        if (load) begin
          r_display <= load_value;
        end else if (r_pending) begin
          r_display <= r_shadow;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // A digit is suppressed when it and every digit to its left hold zero
  always_comb begin
    logic v_zero;
    v_zero   = 1'b1;
    w_lz_sup = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_zero      = v_zero & (r_display[4*k +: 4] == 4'h0);
      w_lz_sup[k] = lz_en & v_zero & (k != 0);
    end
  end

  always_comb begin
    w_lit = !w_guard && !blank_mask[r_idx] && !w_lz_sup[r_idx];
    if (w_lit) begin
      w_seg_on = w_glyph;
      w_dig_on = NUM_DIGITS'(1) << r_idx;
    end else begin
      w_seg_on = 7'h00;
      w_dig_on = '0;
    end
  end

  // Output registers with display polarity applied
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg        <= SEG_OFF;
      r_dig        <= DIG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_on ^ SEG_OFF;
      r_dig        <= w_dig_on ^ DIG_OFF;
      r_frame_tick <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dig        = r_dig;
  assign frame_tick = r_frame_tick;

`ifdef SEG7_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] r_dp_shadow;
  logic [NUM_DIGITS-1:0] r_dp_display;
  logic                  r_dp_out;

  // Decimal points follow exactly the same shadow/display rules as the nibbles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dp_shadow  <= '0;
      r_dp_display <= '0;
      r_dp_out     <= SEG_OFF[0];
    end else begin
      if (load) begin
        r_dp_shadow <= dp_in;
      end
      if (w_wrap) begin
        if (load) begin
          r_dp_display <= dp_in;
        end else if (r_pending) begin
          r_dp_display <= r_dp_shadow;
        end
      end
      r_dp_out <= (w_lit & r_dp_display[r_idx]) ^ SEG_OFF[0];
    end
  end

  assign dp_out = r_dp_out;
`endif

endmodule
